uart_cmd_updown_counter: RTL and testbench

- Parametrised successor to the UART-controlled up/down counter.
- Merges button pulses and received UART command bytes into run/stop, clear and mode controls for a configurable-width, configurable-modulus counter with a prescaled tick.
- Adds a status-report path: on command, streams the counter value back over the UART transmitter as ASCII hex followed by CR LF.
- Sits between the uart rx/tx cores and the FND/LED display logic.

---
 rtl/uart_cmd_updown_counter.sv | 191 +++++++++++++++++++
 tb/tb_uart_cmd_updown_counter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_updown_counter.sv
// rtl/uart_cmd_updown_counter.sv - UART/button controlled up/down counter with ASCII hex status report
module uart_cmd_updown_counter #(
  parameter int CNT_W      = 14,
  parameter int MAX_VAL    = 9999,
  parameter int PRESCALE   = 10_000_000,
  parameter int HEX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       btn,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  output logic [CNT_W-1:0] count,
  output logic             mode,
  output logic             run,
  output logic [1:0]       led_mode,
  output logic [1:0]       led_run_stop,
  output logic             report_drop
);

  localparam int PS_W  = $clog2(PRESCALE);
  localparam int SH_W  = HEX_DIGITS * 4;
  localparam int IDX_W = $clog2(HEX_DIGITS + 2);

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_VAL);
  localparam logic [IDX_W-1:0] IDX_CR   = IDX_W'(HEX_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HEX_DIGITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t            state_q, state_d;
  logic [PS_W-1:0]   presc;
  logic [IDX_W-1:0]  idx;
  logic [SH_W-1:0]   shadow;
  logic [3:0]        nib;
  logic [7:0]        byte_sel;
  logic              rx_r, rx_c, rx_m, rx_s;
  logic              run_ev, clr_ev, mode_ev, tick;

  // Case-insensitive command decode, only while a received byte is valid
  always_comb begin
    rx_r = 1'b0;
    rx_c = 1'b0;
    rx_m = 1'b0;
    rx_s = 1'b0;
    if (rx_done) begin
      case (rx_data)
        8'h52, 8'h72: rx_r = 1'b1;
        8'h43, 8'h63: rx_c = 1'b1;
        8'h4D, 8'h6D: rx_m = 1'b1;
        8'h53, 8'h73: rx_s = 1'b1;
        default: ;
      endcase
    end
  end

  // A button and a UART command of the same kind in one cycle act as a single event
  assign run_ev  = btn[0] | rx_r;
  assign clr_ev  = btn[1] | rx_c;
  assign mode_ev = btn[2] | rx_m;
  assign tick    = run && (presc == PS_LAST);

  // Prescaler: advances only while running, clear restarts the tick period
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (clr_ev) begin
      presc <= '0;
    end else if (run) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // Counter step uses the mode in force before any same-cycle mode toggle
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr_ev) begin
      count <= '0;
    end else if (tick) begin
      if (!mode) begin
        count <= (count == CNT_MAX) ? '0 : count + 1'b1;
      end else begin
        count <= (count == '0) ? CNT_MAX : count - 1'b1;
      end
    end
  end

  // Run/mode toggles and their LED encodings, all registered together
  always_ff @(posedge clk) begin
    if (reset) begin
      run          <= 1'b0;
      mode         <= 1'b0;
      led_mode     <= 2'b01;
      led_run_stop <= 2'b01;
    end else begin
      run          <= run ^ run_ev;
      mode         <= mode ^ mode_ev;
      led_mode     <= (mode ^ mode_ev) ? 2'b10 : 2'b01;
      led_run_stop <= (run ^ run_ev) ? 2'b10 : 2'b01;
    end
  end

  // Select the report byte for the current index: hex digits MSB first, then CR LF
  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < HEX_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib = shadow[SH_W-4-4*i +: 4];
      end
    end
    if (idx == IDX_CR) begin
      byte_sel = 8'h0D;
    end else if (idx == IDX_LAST) begin
      byte_sel = 8'h0A;
    end else if (nib < 4'd10) begin
      byte_sel = 8'h30 + {4'h0, nib};
    end else begin
      byte_sel = 8'h37 + {4'h0, nib};
    end
  end

  // Report FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Report FSM next state; tx_start is a one-cycle request issued from SEND
  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_s) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy && !reset) begin
          tx_start = 1'b1;
          state_d  = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (tx_busy) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx_busy) state_d = (idx == IDX_LAST) ? S_IDLE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Report datapath: snapshot, byte index, held tx_data and dropped-request pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow      <= '0;
      idx         <= '0;
      tx_data     <= 8'h00;
      report_drop <= 1'b0;
    end else begin
      report_drop <= rx_s && (state_q != S_IDLE);
      if (state_q == S_IDLE && rx_s) begin
        shadow <= SH_W'(count);
        idx    <= '0;
      end
      if (state_q == S_LOAD) begin
        tx_data <= byte_sel;
      end
      if (state_q == S_WAIT_LO && !tx_busy && idx != IDX_LAST) begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_updown_counter.sv
// tb/tb_uart_cmd_updown_counter.sv - scoreboard bench for uart_cmd_updown_counter
module tb_uart_cmd_updown_counter;

  localparam int CNT_W = 14;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       btn = 3'b000;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_done = 1'b0;
  logic             tx_busy = 1'b0;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic [CNT_W-1:0] count;
  logic             mode;
  logic             run;
  logic [1:0]       led_mode;
  logic [1:0]       led_run_stop;
  logic             report_drop;

  uart_cmd_updown_counter #(
    .CNT_W(14), .MAX_VAL(9999), .PRESCALE(4), .HEX_DIGITS(4)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .rx_data(rx_data), .rx_done(rx_done),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start), .count(count),
    .mode(mode), .run(run), .led_mode(led_mode), .led_run_stop(led_run_stop),
    .report_drop(report_drop)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         n_start = 0;
  int         n_drop = 0;
  bit         pend = 1'b0;
  int         bcnt = 0;
  bit         prev_done = 1'b1;
  logic       mon_st;
  logic [7:0] mon_e;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_count", count, 0);
    chk("rst_mode", mode, 0);
    chk("rst_run", run, 0);
    chk("rst_led_mode", led_mode, 1);
    chk("rst_led_run_stop", led_run_stop, 1);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_report_drop", report_drop, 0);
  endtask

  // Monitor: compares transmitted bytes against the scoreboard and models the transmitter busy
  always @(negedge clk) begin
    mon_st = tx_start;
    if (report_drop) n_drop++;
    if (mon_st) begin
      n_start++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got byte %02h expected no tx_start", tx_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (tx_data !== mon_e) begin
          n_err++;
          $display("FAIL tx_byte: got %02h expected %02h", tx_data, mon_e);
        end
      end
      n_chk++;
      if (!prev_done) begin
        n_err++;
        $display("FAIL tx_handshake: got start before busy cycle done, expected busy rise/fall first");
      end
      prev_done = 1'b0;
    end
    if (pend) begin
      tx_busy = 1'b1;
      bcnt = 4;
      pend = 1'b0;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) begin
        tx_busy = 1'b0;
        prev_done = 1'b1;
      end
    end
    if (mon_st) pend = 1'b1;
  end

  initial begin
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    chk_reset_outputs();

    // run, first count after four enabled prescaler cycles
    send_rx(8'h72);
    chk("run_after_r", run, 1);
    chk("led_run_after_r", led_run_stop, 2);
    wait_cyc(4);
    chk("count_first_tick", count, 1);
    wait_cyc(36);
    chk("count_after_40", count, 10);

    // wrap up at MAX_VAL, then down wraps 0 to MAX_VAL
    wait_cyc(39956);
    chk("count_at_max", count, 9999);
    wait_cyc(4);
    chk("count_wrap_up", count, 0);
    send_rx(8'h6D);
    chk("mode_down", mode, 1);
    chk("led_mode_down", led_mode, 2);
    wait_cyc(3);
    chk("count_wrap_down", count, 9999);

    // clear coincident with tick, run toggle from both sources at once
    send_rx(8'h4D);
    chk("mode_up_again", mode, 0);
    send_rx(8'h63);
    chk("count_clear_uart", count, 0);
    wait_cyc(28);
    chk("count_seven", count, 7);
    wait_cyc(3);
    btn = 3'b010;
    @(negedge clk);
    btn = 3'b000;
    chk("clr_beats_tick", count, 0);
    chk("run_kept_on_clr", run, 1);
    wait_cyc(3);
    chk("presc_zeroed_hold", count, 0);
    wait_cyc(1);
    chk("presc_zeroed_step", count, 1);
    btn = 3'b001;
    rx_data = 8'h52;
    rx_done = 1'b1;
    @(negedge clk);
    btn = 3'b000;
    rx_done = 1'b0;
    chk("run_toggle_once", run, 0);
    chk("led_stop", led_run_stop, 1);
    wait_cyc(8);
    chk("count_held_stopped", count, 1);

    // report of 0x01A3 while counting continues
    send_rx(8'h43);
    chk("count_clear_stopped", count, 0);
    send_rx(8'h52);
    chk("run_resume", run, 1);
    wait_cyc(1676);
    chk("count_419", count, 419);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    send_rx(8'h73);

    // second request during the report is dropped; unknown byte ignored
    wait_cyc(3);
    send_rx(8'h53);
    send_rx(8'h78);
    chk("run_after_x", run, 1);
    chk("mode_after_x", mode, 0);
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("report_bytes_left", exp_q.size(), 0);
    wait_cyc(20);
    chk("report_drop_pulses", n_drop, 1);
    chk("report_byte_count", n_start, 6);

    // reset in WAIT_LO of byte 2 aborts the report
    send_rx(8'h72);
    chk("run_stop_for_rst", run, 0);
    send_rx(8'h63);
    chk("count_zero_for_rst", count, 0);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h30);
    send_rx(8'h73);
    for (int i = 0; i < 400; i++) begin
      if (n_start >= 9) break;
      @(negedge clk);
    end
    for (int i = 0; i < 50; i++) begin
      if (tx_busy) break;
      @(negedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    reset = 1'b0;
    wait_cyc(40);
    chk("abort_bytes_left", exp_q.size(), 0);
    chk("abort_byte_count", n_start, 9);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
